// File: rtl/add2_sweep_ctrl.sv
// add2_sweep_ctrl
//   Sequencer that exercises a 4-input combinational add2 block. It drives x1..x4
//   through the 16 input vectors in ascending order. Each vector is held for
//   SETTLE_CYCLES cycles, then f is sampled in a single SAMPLE cycle. The captured
//   truth table and a count of ones are kept for an on-board self-check.
//
//   Ports
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     start      begin a sweep (acted on only in IDLE or DONE)
//     abort      cancel a running sweep (acted on only in DRIVE or SAMPLE)
//     f          result returned by the add2 instance
//     x1..x4     current vector; x1 is the MSB
//     vec_idx    index of the vector being driven, equal to {x1,x2,x3,x4}
//     busy       high in DRIVE and SAMPLE
//     done       high in DONE
//     truth      truth[i] holds f captured for vector i
//     ones_count number of captured ones (0..16)
//
//   SETTLE_CYCLES must lie in 1..15 because the settle counter is 4 bits wide.
module add2_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        f,
  output logic        x1,
  output logic        x2,
  output logic        x3,
  output logic        x4,
  output logic [3:0]  vec_idx,
  output logic        busy,
  output logic        done,
  output logic [15:0] truth,
  output logic [4:0]  ones_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [3:0] settle_cnt;

  // The vector bits come straight from the vec_idx register, so they are
  // registered outputs and can never disagree with vec_idx.
  assign {x1, x2, x3, x4} = vec_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      vec_idx    <= 4'd0;
      settle_cnt <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      truth      <= 16'h0000;
      ones_count <= 5'd0;
    end else begin
      case (state)
        // IDLE and DONE both restart on start. Abort is ignored in these states,
        // so start together with abort still restarts.
        IDLE, DONE: begin
          if (start) begin
            state      <= DRIVE;
            vec_idx    <= 4'd0;
            settle_cnt <= 4'd0;
            truth      <= 16'h0000;
            ones_count <= 5'd0;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end

        DRIVE: begin
          if (abort) begin
            state      <= IDLE;
            vec_idx    <= 4'd0;
            settle_cnt <= 4'd0;
            truth      <= 16'h0000;
            ones_count <= 5'd0;
            busy       <= 1'b0;
          end else if (settle_cnt == SETTLE_LAST) begin
            state      <= SAMPLE;
            settle_cnt <= 4'd0;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end

        SAMPLE: begin
          if (abort) begin
            // An aborted sweep discards the sample that is in flight.
            state      <= IDLE;
            vec_idx    <= 4'd0;
            settle_cnt <= 4'd0;
            truth      <= 16'h0000;
            ones_count <= 5'd0;
            busy       <= 1'b0;
          end else begin
            truth[vec_idx] <= f;
            ones_count     <= ones_count + {4'd0, f};
            if (vec_idx == 4'd15) begin
              // Stop on the last vector. vec_idx holds at 15 and never wraps.
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state   <= DRIVE;
              vec_idx <= vec_idx + 4'd1;
            end
          end
        end

        default: begin
          state      <= IDLE;
          vec_idx    <= 4'd0;
          settle_cnt <= 4'd0;
          truth      <= 16'h0000;
          ones_count <= 5'd0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/add2_sweep_ctrl.md
Name: add2_sweep_ctrl

Overview:
- Sequential harness stage that wraps the 4-input combinational add2 function block.
- Upstream side: drives x1..x4 through all 16 input vectors in ascending order.
- Downstream side: samples the single-bit result f for each vector after a programmable settle time.
- Accumulates the 16-entry truth table and a ones-count for on-board self-check in place of a simulation-only testbench.

Parameters:
- SETTLE_CYCLES, default 2: number of cycles each vector is driven before f is sampled. Legal range 1..15; counter is 4 bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a sweep; level sampled on the clock edge; honoured only in IDLE or DONE
- abort  input  1  cancel a running sweep
- f  input  1  result from the add2 instance
- x1  output  1  vector bit 3 (MSB)
- x2  output  1  vector bit 2
- x3  output  1  vector bit 1
- x4  output  1  vector bit 0 (LSB)
- vec_idx  output  4  index of the vector currently driven; equals {x1,x2,x3,x4}
- busy  output  1  high in DRIVE and SAMPLE
- done  output  1  high in DONE
- truth  output  16  truth[i] = f captured for vector i
- ones_count  output  5  number of captured f==1 (0..16)

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, vec_idx=0, x1..x4=0, settle counter=0, busy=0, done=0, truth=16'h0000, ones_count=0. All outputs are registered.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE, start=1 -> DRIVE. On the same edge: vec_idx=0, truth=0, ones_count=0, settle counter=0.
- DRIVE:
  - Settle counter increments each cycle.
  - When the counter equals SETTLE_CYCLES-1 -> SAMPLE, and the counter clears.
  - DRIVE therefore lasts exactly SETTLE_CYCLES cycles.
- SAMPLE lasts one cycle. On the exiting edge:
  - truth[vec_idx] <= f and ones_count <= ones_count + f.
  - If vec_idx==15 -> DONE.
  - Otherwise vec_idx increments and the state returns to DRIVE.
- Vector hold time: each vector is stable for SETTLE_CYCLES+1 cycles. x1..x4 change only on the SAMPLE->DRIVE edge.
- Total latency: with the start edge as edge 0, done rises after edge 16*(SETTLE_CYCLES+1). That is 48 cycles at the default.
- DONE:
  - truth, ones_count and vec_idx=15 hold until start.
  - start=1 in DONE behaves as from IDLE: clears results and restarts at vector 0. done drops on that edge.
- No wrap-around: vec_idx never increments past 15.
- abort:
  - In DRIVE or SAMPLE: next state IDLE, and vec_idx, x1..x4, truth and ones_count all clear to 0. The in-flight sample is discarded.
  - In IDLE or DONE: no effect.
- start and abort in the same cycle: abort wins. In IDLE or DONE, abort has no effect, so start is honoured.
- start asserted in DRIVE or SAMPLE without abort is ignored; the sweep continues undisturbed.
- Reset asserted mid-sweep: immediate return to the reset values above, without waiting for a clock edge.
- f is treated as already settled at the SAMPLE edge. No synchroniser; f comes from same-clock combinational logic.

Test Plan:
1. Reset, then start pulse with f wired as x1^x2^x3^x4, SETTLE_CYCLES=2 -> busy for 48 cycles, done rises 48 cycles after the start edge, truth=16'h6996, ones_count=8.
2. f wired as x1&x2&x3&x4 -> truth=16'h8000, ones_count=1. Separately, f tied to 1 -> truth=16'hFFFF, ones_count=16 (no overflow).
3. Timing check at SETTLE_CYCLES=1:
   - vec_idx steps every 2 cycles.
   - x1..x4 equal vec_idx throughout.
   - done at cycle 32 after start.
4. abort during vector 5 -> next cycle IDLE, busy=0, vec_idx=0, truth=0, ones_count=0. A following start completes a full correct sweep. start+abort together in DONE -> restart occurs.
5. start re-pulsed while busy at vector 7 -> ignored, sweep finishes with correct truth. start in DONE -> done falls and truth clears.
6. rst_n pulled low asynchronously mid-sweep (between clock edges) -> all outputs are 0 before the next clk edge. Release plus start -> normal sweep.
